async_fifo_rd_port: RTL and testbench
=====================================

Name: async_fifo_rd_port

Overview:
Read-side half of the split dual-clock FIFO, clocked entirely by rd_clk. It synchronises the Gray-coded write pointer from the write domain and owns the read pointer. It drives a synchronous-read RAM port and presents the data as a first-word-fall-through valid/ready stream through a 2-entry output buffer. It returns a registered Gray read pointer to the write-side port for its full calculation.

Parameters:
DEPTH, 8, FIFO memory words; power of two, >= 4.
WIDTH, 8, data word width in bits.
ADDR (localparam), $clog2(DEPTH), RAM address width; pointers are ADDR+1 bits.

Ports:
rd_clk  input  1  read-domain clock.
reset  input  1  asynchronous, active-high reset; shared with the write-side port.
wr_ptr_gray  input  ADDR+1  Gray write pointer from the write domain; asynchronous to rd_clk; changes by at most one bit per update.
rd_ptr_gray  output  ADDR+1  registered Gray read pointer, sent to the write domain.
ram_rd_en  output  1  RAM read strobe.
ram_rd_addr  output  ADDR  RAM read address, equal to rd_ptr_bin[ADDR-1:0].
ram_rd_data  input  WIDTH  RAM read data; valid exactly one cycle after ram_rd_en.
m_valid  output  1  output word available.
m_ready  input  1  consumer accepts the word.
m_data  output  WIDTH  head of the output buffer.
empty  output  1  FIFO memory holds no unread words, as seen in the read domain.
rd_level  output  ADDR+1  words remaining in memory, excluding the output buffer.

Behaviour:
- Synchroniser: wr_ptr_gray passes through sync1 then sync2 on rd_clk. wsync_bin = gray2bin(sync2).
- empty = (rd_ptr_gray == sync2). This is combinational from registers.
- rd_level = wsync_bin - rd_ptr_bin, computed modulo 2^(ADDR+1).
- State:
  - rd_ptr_bin, ADDR+1 bits.
  - inflight flag f, set when a read was issued in the previous cycle.
  - Output buffer: 2 entries, count c in 0..2, head/tail index.
- pop = m_valid & m_ready. m_valid = (c != 0). m_data = buffer[head].
- issue = !empty && (c + f - pop) < 2. ram_rd_en = issue.
- On issue, rd_ptr_bin increments on the same edge. rd_ptr_gray is registered as bin2gray(rd_ptr_bin + 1) on that edge, so it never glitches.
- When f = 1, ram_rd_data is written to buffer[tail] at the end of that cycle.
- Per edge: c_next = c + f - pop. Words leave in write order.
- Throughput: 1 word/cycle when m_ready is held high.
- First-word latency: wr_ptr_gray stable before edge E1 gives m_valid = 1 after E4.
- Backpressure: at most 2 words are outstanding (buffer plus in-flight), so no word is ever dropped. m_data is held stable while m_valid & !m_ready.
- Wrap-around: pointer arithmetic is modulo 2^(ADDR+1). The address drops the MSB. empty compares all ADDR+1 bits.
- Simultaneous pop and fill with c = 2: legal. The count is unchanged and the entries rotate.
- Reset values (asserted asynchronously, mid-operation included):
  - rd_ptr_bin = 0, rd_ptr_gray = 0, sync1 = sync2 = 0, f = 0, c = 0, head = tail = 0.
  - Resulting outputs: m_valid = 0, empty = 1, rd_level = 0, ram_rd_en = 0.
  - A read in flight at reset is discarded.
- Deassertion of reset need not be synchronised by this block; the system synchronises it upstream.

Optional Feature:
ASYNC_FIFO_RD_SYNC3_EN
- Defined: the write-pointer synchroniser uses 3 flops, for high-MTBF targets. empty, rd_level and issue use stage 3. First-word latency becomes E5.
- Undefined: 2-flop synchroniser as described above.
- All other behaviour is identical in both cases.

Decomposition:
- Package async_fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterised on width via a let or a parameterised class static function.
  - Localparam OUTBUF_DEPTH = 2.
  - The shared pointer typedef convention.
- Sub-module gray_ptr_sync (parameters WIDTH, STAGES) is a multi-flop synchroniser with asynchronous reset. It is reused by the write-side port.

Test Plan:
1. Assert reset, release, no writes -> m_valid = 0, empty = 1, rd_level = 0, rd_ptr_gray = 0, ram_rd_en never asserted.
2. Step wr_ptr_gray 0 -> 1 before edge E1, RAM returns 0xA5, m_ready = 0 -> ram_rd_en high in the cycle after E2, m_valid = 1 after E4, m_data = 0xA5, rd_ptr_gray = 1.
3. Set the write pointer to 8 (gray 0b1100, DEPTH 8) with m_ready = 1 -> 8 consecutive words in order at 1/cycle after the pipeline fills, then empty = 1, rd_level = 0.
4. Set the write pointer to 5 with m_ready = 0 -> exactly 2 reads issued, rd_level = 3, c = 2, m_data stable. Raise m_ready -> remaining 3 words follow with no gap or loss.
5. Stream 20 words through DEPTH 8 with random m_ready -> address wraps 7 -> 0, rd_ptr_bin MSB toggles, all 20 words arrive in order with no duplicates.
6. Pulse reset while c = 2, f = 1 -> outputs return to their reset values immediately. After release, with the write pointer reset to 0, no stale word appears.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the split dual-clock FIFO: Gray/binary pointer conversion
// and output-buffer sizing, used by both the read-side and write-side ports.
package async_fifo_pkg;

  localparam int OUTBUF_DEPTH = 2;

  // Pointers are ADDR+1 bits wide; the extra MSB is the wrap bit that tells
  // a full memory apart from an empty one when the low address bits match.
  virtual class gray_conv #(parameter int W = 4);
    typedef logic [W-1:0] ptr_t;

    static function ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
    endfunction

    static function ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
    endfunction
  endclass

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
// Shared by the read-side and write-side FIFO ports.
module gray_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_port.sv
// Read-side port of the dual-clock FIFO: synchronised write pointer, read
// pointer, sync-read RAM port and a 2-entry FWFT output buffer.
// Define ASYNC_FIFO_RD_SYNC3_EN for a 3-flop write-pointer synchroniser.
module async_fifo_rd_port
  import async_fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int ADDR  = $clog2(DEPTH)
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic [ADDR:0]    wr_ptr_gray,
  output logic [ADDR:0]    rd_ptr_gray,
  output logic             ram_rd_en,
  output logic [ADDR-1:0]  ram_rd_addr,
  input  logic [WIDTH-1:0] ram_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             empty,
  output logic [ADDR:0]    rd_level
);

`ifdef ASYNC_FIFO_RD_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif
  localparam int PW = ADDR + 1;

  logic [ADDR:0]    wsync_gray;
  logic [ADDR:0]    wsync_bin;
  logic [ADDR:0]    rd_ptr_bin;
  logic             inflight;
  logic [1:0]       cnt;
  logic [1:0]       occ;
  logic             head;
  logic             tail;
  logic             pop;
  logic             issue;
  logic [WIDTH-1:0] obuf [OUTBUF_DEPTH];

  gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
    .clk   (rd_clk),
    .reset (reset),
    .d     (wr_ptr_gray),
    .q     (wsync_gray)
  );

  assign wsync_bin   = gray_conv#(PW)::gray2bin(wsync_gray);
  assign empty       = (rd_ptr_gray == wsync_gray);
  assign rd_level    = wsync_bin - rd_ptr_bin;
  assign ram_rd_addr = rd_ptr_bin[ADDR-1:0];

  // Stream handshake: a word transfers on any edge where m_valid && m_ready;
  // m_valid never drops and m_data never changes until that transfer happens.
  assign m_valid = (cnt != 2'd0);
  assign m_data  = obuf[head];
  assign pop     = m_valid & m_ready;

  // Buffered plus in-flight words never exceed 2, so occ fits in 2 bits and
  // a read is only launched when its data is guaranteed a buffer slot.
  assign occ       = cnt + {1'b0, inflight} - {1'b0, pop};
  assign issue     = !empty && (occ < 2'(OUTBUF_DEPTH));
  assign ram_rd_en = issue;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      rd_ptr_bin  <= '0;
      rd_ptr_gray <= '0;
      inflight    <= 1'b0;
      cnt         <= 2'd0;
      head        <= 1'b0;
      tail        <= 1'b0;
    end else begin
      inflight <= issue;
      cnt      <= occ;
      if (issue) begin
        rd_ptr_bin  <= rd_ptr_bin + 1'b1;
        rd_ptr_gray <= gray_conv#(PW)::bin2gray(rd_ptr_bin + 1'b1);
      end
      if (inflight) tail <= ~tail;
      if (pop)      head <= ~head;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (inflight) obuf[tail] <= ram_rd_data;
  end

endmodule

// File: tb/tb_async_fifo_rd_port.sv
// Bench for async_fifo_rd_port: behavioural write side + RAM, scoreboard on
// the output stream, directed latency/backpressure/reset cases plus a random stream.
module tb_async_fifo_rd_port;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int ADDR  = $clog2(DEPTH);

  logic             rd_clk;
  logic             reset;
  logic [ADDR:0]    wr_ptr_gray;
  logic [ADDR:0]    rd_ptr_gray;
  logic             ram_rd_en;
  logic [ADDR-1:0]  ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             empty;
  logic [ADDR:0]    rd_level;

  async_fifo_rd_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .rd_clk      (rd_clk),
    .reset       (reset),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .empty       (empty),
    .rd_level    (rd_level)
  );

  // ---------------- clock / reset ----------------
  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- RAM + write-side model ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int wr;
  int popped_total;

  always @(posedge rd_clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  function automatic logic [ADDR:0] to_gray(input int n);
    logic [ADDR:0] b;
    b = n[ADDR:0];
    return b ^ (b >> 1);
  endfunction

  // ---------------- scoreboard / counters ----------------
  int n_checks;
  int n_pass;
  int cyc, en_cnt, valid_cnt, pop_cnt, first_pop, last_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge rd_clk) begin
    cyc++;
    if (!reset) begin
      if (ram_rd_en) en_cnt++;
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        else check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
        if (pop_cnt == 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
        popped_total++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [WIDTH-1:0] d);
    mem[wr % DEPTH] = d;
    exp_q.push_back(d);
    wr++;
    wr_ptr_gray = to_gray(wr);
  endtask

  task automatic do_reset();
    @(posedge rd_clk); #2;
    reset = 1'b1;
    wr = 0;
    wr_ptr_gray = '0;
    exp_q.delete();
    repeat (2) @(posedge rd_clk);
    #2 reset = 1'b0;
  endtask

  task automatic step_write(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk); #2;
      write_word(WIDTH'($urandom_range(0, 255)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_wr;
    int base;
    reset = 1'b1;
    m_ready = 1'b0;
    wr_ptr_gray = '0;
    wr = 0;
    popped_total = 0;
    n_checks = 0;
    n_pass = 0;

    // 1: reset state, idle
    do_reset();
    check("t1_m_valid", 32'(m_valid), 0);
    check("t1_empty", 32'(empty), 1);
    check("t1_rd_level", 32'(rd_level), 0);
    check("t1_rd_ptr_gray", 32'(rd_ptr_gray), 0);
    en_cnt = 0;
    repeat (10) @(posedge rd_clk);
    #1 check("t1_no_reads", 32'(en_cnt), 0);

    // 2: first-word latency
    @(posedge rd_clk); #2;
    write_word(8'hA5);
    @(posedge rd_clk);                 // E1
    @(posedge rd_clk); #1;             // E2
    check("t2_rd_en_e2", 32'(ram_rd_en), 1);
    check("t2_empty_e2", 32'(empty), 0);
    check("t2_level_e2", 32'(rd_level), 1);
    @(posedge rd_clk); #1;             // E3
    check("t2_rd_en_e3", 32'(ram_rd_en), 0);
    check("t2_rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(1)));
    check("t2_valid_e3", 32'(m_valid), 0);
    @(posedge rd_clk); #1;             // E4
    check("t2_valid_e4", 32'(m_valid), 1);
    check("t2_data_e4", 32'(m_data), 32'hA5);
    repeat (3) @(posedge rd_clk);
    #1 check("t2_data_hold", 32'(m_data), 32'hA5);
    #1 m_ready = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1 check("t2_drained", exp_q.size(), 0);

    // 3: streaming at full rate
    pop_cnt = 0;
    step_write(8);
    repeat (12) @(posedge rd_clk);
    #1;
    check("t3_pops", pop_cnt, 8);
    check("t3_gapless", last_pop - first_pop, 7);
    check("t3_empty", 32'(empty), 1);
    check("t3_level", 32'(rd_level), 0);
    check("t3_valid", 32'(m_valid), 0);
    check("t3_rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(wr)));

    // 4: backpressure
    #1 m_ready = 1'b0;
    en_cnt = 0;
    pop_cnt = 0;
    base = wr;
    step_write(5);
    repeat (10) @(posedge rd_clk);
    #1;
    check("t4_level", 32'(rd_level), 3);
    check("t4_reads", en_cnt, 2);
    check("t4_valid", 32'(m_valid), 1);
    check("t4_head", 32'(m_data), 32'(exp_q[0]));
    check("t4_rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(base + 2)));
    repeat (4) @(posedge rd_clk);
    #1 check("t4_head_stable", 32'(m_data), 32'(exp_q[0]));
    #1 m_ready = 1'b1;
    repeat (10) @(posedge rd_clk);
    #1;
    check("t4_pops", pop_cnt, 5);
    check("t4_gapless", last_pop - first_pop, 4);
    check("t4_drained", exp_q.size(), 0);
    check("t4_empty", 32'(empty), 1);

    // 5: random stream across pointer wrap
    pop_cnt = 0;
    n_wr = 0;
    for (int k = 0; k < 600 && (n_wr < 20 || exp_q.size() != 0); k++) begin
      @(posedge rd_clk); #2;
      m_ready = 1'($urandom_range(0, 1));
      if (n_wr < 20 && (wr - popped_total) < DEPTH && $urandom_range(0, 3) != 0) begin
        write_word(WIDTH'($urandom_range(0, 255)));
        n_wr++;
      end
    end
    m_ready = 1'b1;
    repeat (6) @(posedge rd_clk);
    #1;
    check("t5_writes", n_wr, 20);
    check("t5_pops", pop_cnt, 20);
    check("t5_drained", exp_q.size(), 0);
    check("t5_empty", 32'(empty), 1);
    check("t5_level", 32'(rd_level), 0);
    check("t5_rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(wr)));

    // 6: asynchronous reset mid-stream
    step_write(5);
    @(posedge rd_clk); #2;
    reset = 1'b1;
    #1;
    check("t6_valid", 32'(m_valid), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_level", 32'(rd_level), 0);
    check("t6_rd_en", 32'(ram_rd_en), 0);
    check("t6_rd_ptr_gray", 32'(rd_ptr_gray), 0);
    wr = 0;
    wr_ptr_gray = '0;
    exp_q.delete();
    repeat (2) @(posedge rd_clk);
    #2 reset = 1'b0;
    valid_cnt = 0;
    en_cnt = 0;
    repeat (10) @(posedge rd_clk);
    #1;
    check("t6_no_stale", valid_cnt, 0);
    check("t6_no_reads", en_cnt, 0);
    check("t6_ptr_idle", 32'(rd_ptr_gray), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
